hssaer_tx_fifo_enc: RTL and testbench

Next-generation HSSAER transmit encoder with a parametrised event width and a built-in input FIFO behind a valid/ready handshake. It serialises one event word per frame onto a single NRZI line, one bit per clk, with a configurable inter-frame gap. It emits programmable-period keepalive symbols while idle. It sits between the AER event arbiter and the board pad/serialiser, and replaces the fixed 2-bit DDR encoder path for single-rate links.

---
 rtl/hssaer_tx_fifo_enc.sv | 248 ++++++++++++++++++++++++
 tb/tb_hssaer_tx_fifo_enc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hssaer_tx_fifo_enc.sv
// HSSAER single-rate transmit encoder with an input FIFO.
// Frames ("11" + DSIZE data bits MSB first [+ parity] + GAP zeros) and
// keepalive symbols ("1" + GAP zeros) are sent NRZI, one bit per clk.
// Optional build macro: HSSAER_TX_PARITY_EN appends an even-parity bit.
module hssaer_tx_fifo_enc #(
    parameter int unsigned DSIZE     = 32,
    parameter int unsigned FIFO_AW   = 4,
    parameter int unsigned GAP       = 2,
    parameter int unsigned KA_PERIOD = 16
) (
    input  logic               clk,
    input  logic               _rst,
    input  logic [DSIZE-1:0]   s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic               keepalive_i,
    output logic               tx_o,
    output logic               run_o,
    output logic               first_o,
    output logic               last_o,
    output logic               alive_o,
    output logic [FIFO_AW:0]   fifo_level_o
);

    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam int unsigned LW      = FIFO_AW + 1;
    localparam int unsigned CNT_MAX = (DSIZE > GAP) ? DSIZE : GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned KW      = $clog2(KA_PERIOD + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd4;
    localparam logic [2:0] ST_KA   = 3'd5;
`ifdef HSSAER_TX_PARITY_EN
    localparam logic [2:0] ST_PAR  = 3'd3;
`endif

    // FIFO storage and pointers
    logic [DSIZE-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0]      level_q, level_d;
    logic               ready_q;
    logic               push, pop, empty;
    logic [DSIZE-1:0]   head;

    // Encoder state
    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DSIZE-1:0]   sh_q, sh_d;
    logic [KW-1:0]      ka_q, ka_d;
    logic               tx_q, tx_d;
    logic               run_q, run_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               alive_q, alive_d;
    logic               bit_l;
    logic               start_frame;
`ifdef HSSAER_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    assign push  = s_valid_i & ready_q;
    assign empty = (level_q == '0);
    assign head  = mem_q[rptr_q];

    // Next FIFO occupancy; ready is precomputed so it is registered
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO data write (no reset needed on storage)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= s_data_i;
        end
    end

    // FIFO pointers, occupancy and ready flag
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            level_q <= level_d;
            ready_q <= (level_d != LW'(DEPTH));
        end
    end

    // Encoder next state; bit_l is the logical bit going onto the line next
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        ka_d        = '0;
        pop         = 1'b0;
        bit_l       = 1'b0;
        run_d       = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        alive_d     = 1'b0;
        start_frame = 1'b0;
`ifdef HSSAER_TX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    start_frame = 1'b1;
                end else if (keepalive_i && !push) begin
                    // a word arriving this edge beats the keepalive
                    if (ka_q == KW'(KA_PERIOD - 1)) begin
                        state_d = ST_KA;
                        bit_l   = 1'b1;
                        alive_d = 1'b1;
                    end else begin
                        ka_d = ka_q + 1'b1;
                    end
                end
            end
            ST_PRE: begin
                run_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d = CW'(1);
                    bit_l = 1'b1;
                end else begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    bit_l   = sh_q[DSIZE-1];
                    sh_d    = {sh_q[DSIZE-2:0], 1'b0};
                end
            end
            ST_DATA: begin
                if (cnt_q != CW'(DSIZE - 1)) begin
                    cnt_d = cnt_q + 1'b1;
                    bit_l = sh_q[DSIZE-1];
                    sh_d  = {sh_q[DSIZE-2:0], 1'b0};
                    run_d = 1'b1;
`ifdef HSSAER_TX_PARITY_EN
                    last_d = 1'b0;
`else
                    last_d = (cnt_q == CW'(DSIZE - 2));
`endif
                end else begin
`ifdef HSSAER_TX_PARITY_EN
                    state_d = ST_PAR;
                    bit_l   = par_q;
                    run_d   = 1'b1;
                    last_d  = 1'b1;
`else
                    state_d = ST_GAP;
                    cnt_d   = '0;
`endif
                end
            end
`ifdef HSSAER_TX_PARITY_EN
            ST_PAR: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
`endif
            ST_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    if (!empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_KA: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame launch: pop the head word and put the first preamble bit out
        if (start_frame) begin
            pop     = 1'b1;
            state_d = ST_PRE;
            cnt_d   = '0;
            sh_d    = head;
            bit_l   = 1'b1;
            run_d   = 1'b1;
            first_d = 1'b1;
`ifdef HSSAER_TX_PARITY_EN
            par_d   = ^head;
`endif
        end

        tx_d = tx_q ^ bit_l;
    end

    // Encoder state and registered line outputs
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            ka_q    <= '0;
            tx_q    <= 1'b0;
            run_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            alive_q <= 1'b0;
`ifdef HSSAER_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ka_q    <= ka_d;
            tx_q    <= tx_d;
            run_q   <= run_d;
            first_q <= first_d;
            last_q  <= last_d;
            alive_q <= alive_d;
`ifdef HSSAER_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign s_ready_o    = ready_q;
    assign tx_o         = tx_q;
    assign run_o        = run_q;
    assign first_o      = first_q;
    assign last_o       = last_q;
    assign alive_o      = alive_q;
    assign fifo_level_o = level_q;

endmodule

// File: tb/tb_hssaer_tx_fifo_enc.sv
// Self-checking bench for hssaer_tx_fifo_enc (DSIZE=8, GAP=2, KA_PERIOD=16).
module tb_hssaer_tx_fifo_enc;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int GP = 2;
    localparam int KP = 16;
`ifdef HSSAER_TX_PARITY_EN
    localparam int FLEN   = 11;
    localparam bit PAR_ON = 1'b1;
`else
    localparam int FLEN   = 10;
    localparam bit PAR_ON = 1'b0;
`endif
    localparam int NS = FLEN + GP;

    logic          clk = 1'b0;
    logic          _rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          keepalive;
    logic          tx, run, first, last, alive;
    logic [AW:0]   fifo_level;

    always #5 clk = ~clk;

    hssaer_tx_fifo_enc #(
        .DSIZE(DW), .FIFO_AW(AW), .GAP(GP), .KA_PERIOD(KP)
    ) dut (
        .clk(clk), ._rst(_rst),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .keepalive_i(keepalive),
        .tx_o(tx), .run_o(run), .first_o(first), .last_o(last), .alive_o(alive),
        .fifo_level_o(fifo_level)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line receiver: decodes NRZI frames back into data words
    logic          mon_en = 1'b0;
    logic          mon_prev = 1'b0;
    int            mon_cnt = 0;
    logic [DW-1:0] mon_sh = '0;
    logic [DW-1:0] got_q[$];
    logic          mon_bit;

    initial begin
        forever begin
            @(posedge clk); #1;
            mon_bit  = tx ^ mon_prev;
            mon_prev = tx;
            if (first) begin
                mon_cnt = 1;
            end else if (mon_cnt != 0) begin
                if (mon_cnt >= 2 && mon_cnt < 2 + DW) mon_sh = {mon_sh[DW-2:0], mon_bit};
                mon_cnt++;
                if (mon_cnt == FLEN) begin
                    if (mon_en) got_q.push_back(mon_sh);
                    mon_cnt = 0;
                end
            end
        end
    end

    // Vector table: data word and hand-derived logical bits {11, data, parity}
    typedef struct {
        logic [7:0]  data;
        logic [10:0] bits;
    } vec_t;
    vec_t vecs[6];

    logic [15:0] got_b, got_f, got_l, got_r, got_t, exp_b;
    logic        prev;
    logic        tr_tx[48];
    logic        tr_f[48];
    int          f1, f2, nf, tog, na, na2, tog2, c, pushed, maxlvl;
    int          ka_t[8];
    bit          found, saw_full, saw_refill, acc;

    initial begin
        vecs[0] = '{8'hA5, 11'b11_10100101_0};
        vecs[1] = '{8'h00, 11'b11_00000000_0};
        vecs[2] = '{8'hFF, 11'b11_11111111_0};
        vecs[3] = '{8'h07, 11'b11_00000111_1};
        vecs[4] = '{8'h80, 11'b11_10000000_1};
        vecs[5] = '{8'h3C, 11'b11_00111100_0};

        s_data = '0; s_valid = 1'b0; keepalive = 1'b0;
        _rst = 1'b1;
        #2 _rst = 1'b0;
        #3;
        check("rst_tx", tx, 0);
        check("rst_run", run, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", s_ready, 0);
        repeat (2) @(negedge clk);
        _rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("ready_after_rst", s_ready, 1);

        // Table: single frames into an empty FIFO from idle
        for (int v = 0; v < 6; v++) begin
            @(negedge clk); s_data = vecs[v].data; s_valid = 1'b1;
            @(posedge clk); #1; s_valid = 1'b0;
            check("push_level", fifo_level, 1);
            prev = tx;
            got_b = '0; got_f = '0; got_l = '0; got_r = '0; got_t = '0;
            for (int i = 0; i < NS; i++) begin
                @(posedge clk); #1;
                got_b = {got_b[14:0], tx ^ prev};
                prev  = tx;
                got_f = {got_f[14:0], first};
                got_l = {got_l[14:0], last};
                got_r = {got_r[14:0], run};
                got_t = {got_t[14:0], tx};
            end
            if (PAR_ON) exp_b = 16'(vecs[v].bits) << GP;
            else        exp_b = 16'(vecs[v].bits >> 1) << GP;
            check($sformatf("bits_%02h", vecs[v].data), got_b, exp_b);
            check($sformatf("first_%02h", vecs[v].data), got_f, 16'(1) << (NS - 1));
            check($sformatf("last_%02h", vecs[v].data), got_l, 16'(1) << GP);
            check($sformatf("run_%02h", vecs[v].data), got_r, ((16'(1) << FLEN) - 16'(1)) << GP);
            if (v == 0) check("tx_seq_a5", got_t[NS-1 -: 10], 10'b1011000110);
            check("level_after", fifo_level, 0);
            repeat (2) @(posedge clk);
        end

        // Back-to-back frames: 0x00 then 0xFF on consecutive cycles
        @(negedge clk); s_data = 8'h00; s_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); s_data = 8'hFF;
        @(posedge clk); #1; s_valid = 1'b0;
        tr_tx[0] = tx; tr_f[0] = first;
        for (int i = 1; i < 48; i++) begin
            @(posedge clk); #1;
            tr_tx[i] = tx; tr_f[i] = first;
        end
        nf = 0; f1 = 0; f2 = 0;
        for (int i = 0; i < 48; i++) begin
            if (tr_f[i]) begin
                if (nf == 0) f1 = i; else if (nf == 1) f2 = i;
                nf++;
            end
        end
        check("b2b_first_count", nf, 2);
        check("b2b_first_spacing", f2 - f1, NS);
        if (nf == 2 && f2 > 0) begin
            tog = 0;
            for (int j = 0; j < 10; j++) if (tr_tx[f2+j] != tr_tx[f2+j-1]) tog++;
            check("b2b_ff_toggles", tog, 10);
            check("b2b_ff_end_level", tr_tx[f2+FLEN-1], tr_tx[f2-1]);
        end
        check("b2b_level", fifo_level, 0);

        // Keepalive period while idle, then disabled
        keepalive = 1'b1;
        na = 0; tog = 0; prev = tx;
        for (c = 0; c < 120 && na < 4; c++) begin
            @(posedge clk); #1;
            if (tx != prev) tog++;
            prev = tx;
            if (alive) begin ka_t[na] = c; na++; end
        end
        keepalive = 1'b0;
        check("ka_pulses", na, 4);
        for (int i = 1; i < na; i++) check("ka_period", ka_t[i] - ka_t[i-1], KP + 1 + GP);
        check("ka_toggles", tog, na);
        na2 = 0; tog2 = 0; prev = tx;
        repeat (40) begin
            @(posedge clk); #1;
            if (tx != prev) tog2++;
            prev = tx;
            if (alive) na2++;
        end
        check("ka_off_pulses", na2, 0);
        check("ka_off_toggles", tog2, 0);

        // Keepalive/frame collision: push lands on the edge the KA would fire
        keepalive = 1'b1;
        found = 1'b0;
        for (c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (alive) found = 1'b1;
        end
        check("coll_ref_ka", found, 1);
        repeat (18) @(posedge clk);
        #1; s_data = 8'h5A; s_valid = 1'b1;
        @(posedge clk); #1; s_valid = 1'b0;
        check("coll_no_alive", alive, 0);
        check("coll_no_first_yet", first, 0);
        @(posedge clk); #1;
        check("coll_first", first, 1);
        check("coll_alive_still0", alive, 0);
        keepalive = 1'b0;
        repeat (NS + 4) @(posedge clk);

        // Back-pressure: hold s_valid with a busy line, all words in order
        got_q.delete();
        mon_en = 1'b1;
        pushed = 0; saw_full = 1'b0; saw_refill = 1'b0; maxlvl = 0;
        for (c = 0; c < 600 && pushed < 20; c++) begin
            @(negedge clk);
            s_data = 8'(8'h10 + pushed); s_valid = 1'b1;
            acc = s_ready;
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            if (fifo_level == 16 && !saw_full) begin
                check("bp_full_ready", s_ready, 0);
                saw_full = 1'b1;
            end else if (saw_full && !saw_refill && fifo_level == 15) begin
                check("bp_refill_ready", s_ready, 1);
                saw_refill = 1'b1;
            end
            @(posedge clk);
            if (acc) pushed++;
        end
        #1 s_valid = 1'b0;
        check("bp_pushed", pushed, 20);
        check("bp_saw_full", saw_full, 1);
        check("bp_saw_refill", saw_refill, 1);
        check("bp_max_level", maxlvl, 16);
        for (c = 0; c < 600 && got_q.size() < 20; c++) @(posedge clk);
        #1 check("bp_rx_count", got_q.size(), 20);
        for (int i = 0; i < got_q.size() && i < 20; i++)
            check($sformatf("bp_word_%0d", i), got_q[i], 8'(8'h10 + i));
        mon_en = 1'b0;
        repeat (4) @(posedge clk);

        // Reset during DATA bit 4 with a second word still queued
        @(negedge clk); s_data = tx ? 8'hC3 : 8'hE3; s_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); s_data = 8'h3C;
        @(posedge clk); #1; s_valid = 1'b0;
        check("rstmid_first", first, 1);
        repeat (5) @(posedge clk);
        #1;
        check("rstmid_pre_run", run, 1);
        check("rstmid_pre_tx", tx, 1);
        check("rstmid_pre_level", fifo_level, 1);
        #2 _rst = 1'b0;
        #1;
        check("rstmid_tx", tx, 0);
        check("rstmid_run", run, 0);
        check("rstmid_level", fifo_level, 0);
        check("rstmid_ready", s_ready, 0);
        repeat (2) @(negedge clk);
        _rst = 1'b1;
        tog = 0; nf = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (tx != 1'b0) tog++;
            if (run || first) nf++;
        end
        check("rstmid_quiet_tx", tog, 0);
        check("rstmid_quiet_run", nf, 0);
        check("rstmid_ready_after", s_ready, 1);
        check("rstmid_level_after", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
